mult_err_monitor: RTL and testbench
===================================

MULT_ERR_MONITOR -- requirements
Module: mult_err_monitor

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 6: operand width of the signed squarer under test.
REQ-002 SHALL have parameter OUT_WIDTH, default 2*BIT_WIDTH: width of the product under test.
REQ-003 SHALL have parameter CNT_WIDTH, default 17: width of the sample and error counters (covers 100000 samples).
REQ-004 SHALL have parameter ACC_WIDTH, default 32: width of the error accumulators.
REQ-005 clk  input  1  rising-edge clock; the block has one clock.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 start  input  1  pulse that begins a run; sampled only in IDLE or DONE.
REQ-008 num_samples  input  CNT_WIDTH  samples in the run; sampled with start.
REQ-009 in_valid  input  1  a sample beat (inp, out) is present.
REQ-010 in_ready  output  1  the block accepts the beat this cycle.
REQ-011 inp  input  BIT_WIDTH  signed operand applied to the approximate circuit.
REQ-012 out  input  OUT_WIDTH  signed approximate result for inp.
REQ-013 busy  output  1  state is RUN or DRAIN.
REQ-014 done  output  1  high while in DONE.
REQ-015 sample_cnt  output  CNT_WIDTH  number of beats accumulated.
REQ-016 err_cnt  output  CNT_WIDTH  number of beats with nonzero error.
REQ-017 max_abs_err  output  OUT_WIDTH+1  largest absolute error seen.
REQ-018 sum_abs_err  output  ACC_WIDTH  sum of absolute errors, saturating.
REQ-019 ovf  output  1  sticky flag: an accumulator or counter saturated.

Function
REQ-020 SHALL compute the exact result as signed inp*inp in OUT_WIDTH bits, and the error as out minus exact in OUT_WIDTH+1 signed bits.
REQ-021 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-022 State transitions:
- IDLE/DONE + start -> RUN, clearing all statistics and latching num_samples.
- start with num_samples=0 -> DRAIN.
- RUN -> DRAIN in the cycle the last beat is accepted.
- DRAIN -> DONE once the pipeline is empty.
REQ-023 in_ready SHALL be 1 only in RUN while the accepted count < num_samples; a beat is accepted when in_valid && in_ready.
REQ-024 Pipeline:
- stage 1 registers the accepted inp/out.
- stage 2 computes the error and updates the statistics.
- Statistics outputs reflect a beat 2 cycles after acceptance.
REQ-025 A start pulse while busy SHALL be ignored.
REQ-026 sum_abs_err and the counters SHALL saturate at all-ones instead of wrapping, and set ovf.
REQ-027 Back-to-back beats (in_valid held high) SHALL be accepted at 1 per cycle with no bubbles.
REQ-028 done SHALL stay high, with the statistics held, until the next accepted start.

Reset
REQ-029 rst SHALL force state IDLE and set in_ready, busy, done, ovf, all counters and accumulators, and the pipeline valid bits to 0.
REQ-030 rst asserted mid-run SHALL discard in-flight beats; the first start after reset begins a clean run.

Configuration
REQ-031 With ERR_SQ_EN defined, the block SHALL add output sum_sq_err (2*ACC_WIDTH bits, saturating): the sum of error squared, updated in stage 2 and setting ovf on saturation.
REQ-032 Without ERR_SQ_EN, the sum_sq_err port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 Package mult_err_pkg SHALL hold the default widths and the state enum type (IDLE, RUN, DRAIN, DONE).
REQ-034 Sub-module mult_err_calc (combinational) SHALL compute the exact square, the signed error and the absolute error; the top holds the FSM, pipeline and accumulators.

Verification
REQ-035 Scenarios the bench SHALL cover:
- num_samples=3, beats (inp=-32,out=1024), (5,24), (3,9) -> done; sample_cnt=3, err_cnt=1, max_abs_err=1, sum_abs_err=1.
- num_samples=0, start -> done 2 cycles later; all statistics 0; in_ready never high.
- 100000 random beats with out equal to exact -> err_cnt=0, sum_abs_err=0, sample_cnt=100000; throughput 1 beat per cycle.
- ACC_WIDTH=8, num_samples=4, each beat error -100 -> sum_abs_err=255, ovf=1.
- rst asserted after 2 of 5 beats -> IDLE, all outputs 0; a new run of 1 beat (inp=-1,out=2) -> err_cnt=1, max_abs_err=1.
- in_valid toggled every other cycle and start pulsed mid-run -> start ignored; counts match the accepted beats only.

Source files
------------

// File: rtl/mult_err_pkg.sv
// Shared widths and FSM state type for the squarer error monitor.
package mult_err_pkg;

  localparam int unsigned DEF_BIT_WIDTH = 6;
  localparam int unsigned DEF_OUT_WIDTH = 2 * DEF_BIT_WIDTH;
  localparam int unsigned DEF_CNT_WIDTH = 17;
  localparam int unsigned DEF_ACC_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/mult_err_calc.sv
// Combinational error datapath: exact signed square of inp, signed error of
// the approximate result against it, and the error magnitude.
module mult_err_calc
  import mult_err_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int unsigned OUT_WIDTH = 2 * BIT_WIDTH
) (
  input  logic [BIT_WIDTH-1:0] inp,
  input  logic [OUT_WIDTH-1:0] out,
  output logic [OUT_WIDTH:0]   err,
  output logic [OUT_WIDTH:0]   abs_err
);

  localparam int unsigned EW = OUT_WIDTH + 1;

  logic signed [OUT_WIDTH-1:0] inp_ext;
  logic signed [OUT_WIDTH-1:0] exact;
  logic signed [EW-1:0]        err_s;

  // Square is taken modulo 2^OUT_WIDTH; error gets one extra bit so it never wraps.
  always_comb begin
    inp_ext = OUT_WIDTH'($signed(inp));
    exact   = inp_ext * inp_ext;
    err_s   = EW'($signed(out)) - EW'(exact);
    err     = err_s;
    // Negating the most negative error still yields the right unsigned magnitude.
    abs_err = err_s[EW-1] ? (~err_s + EW'(1)) : err_s;
  end

endmodule

// File: rtl/mult_err_monitor.sv
// Error monitor for an approximate signed squarer: accepts (inp, out) beats,
// runs a two-stage pipeline and accumulates error statistics per run.
// Optional feature: define ERR_SQ_EN to add the saturating sum_sq_err output.
module mult_err_monitor
  import mult_err_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int unsigned OUT_WIDTH = 2 * BIT_WIDTH,
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_samples,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] inp,
  input  logic [OUT_WIDTH-1:0] out,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] sample_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic [OUT_WIDTH:0]   max_abs_err,
  output logic [ACC_WIDTH-1:0] sum_abs_err,
  output logic                 ovf
`ifdef ERR_SQ_EN
  ,
  output logic [2*ACC_WIDTH-1:0] sum_sq_err
`endif
);

  localparam int unsigned EW = OUT_WIDTH + 1;
  localparam int unsigned SW = ((ACC_WIDTH > EW) ? ACC_WIDTH : EW) + 1;

  state_e               state_q;
  logic [CNT_WIDTH-1:0] num_q;
  logic [CNT_WIDTH-1:0] acc_q;
  logic                 s1_valid_q;
  logic [BIT_WIDTH-1:0] s1_inp_q;
  logic [OUT_WIDTH-1:0] s1_out_q;

  logic                 accept;
  logic                 start_ok;
  logic [EW-1:0]        err;
  logic [EW-1:0]        abs_err;
  logic [SW-1:0]        sum_ext;
  logic                 sum_sat;
  logic [ACC_WIDTH-1:0] sum_nxt;

  assign accept   = in_valid && in_ready;
  // A start is honoured only when no run is in progress.
  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));

  mult_err_calc #(
    .BIT_WIDTH(BIT_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_calc (
    .inp    (s1_inp_q),
    .out    (s1_out_q),
    .err    (err),
    .abs_err(abs_err)
  );

  // Saturating next value of the absolute-error sum.
  always_comb begin
    sum_ext = SW'(sum_abs_err) + SW'(abs_err);
    sum_sat = |sum_ext[SW-1:ACC_WIDTH];
    sum_nxt = sum_sat ? '1 : sum_ext[ACC_WIDTH-1:0];
  end

`ifdef ERR_SQ_EN
  localparam int unsigned QW = ((2 * ACC_WIDTH > 2 * EW) ? 2 * ACC_WIDTH : 2 * EW) + 1;

  logic [2*EW-1:0]        sq_err;
  logic [QW-1:0]          sq_ext;
  logic                   sq_sat;
  logic [2*ACC_WIDTH-1:0] sq_nxt;

  // Saturating next value of the squared-error sum.
  always_comb begin
    sq_err = abs_err * abs_err;
    sq_ext = QW'(sum_sq_err) + QW'(sq_err);
    sq_sat = |sq_ext[QW-1:2*ACC_WIDTH];
    sq_nxt = sq_sat ? '1 : sq_ext[2*ACC_WIDTH-1:0];
  end
`endif

  // Run control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      num_q    <= '0;
      acc_q    <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            num_q <= num_samples;
            acc_q <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            if (num_samples == '0) begin
              state_q  <= DRAIN;
              in_ready <= 1'b0;
            end else begin
              state_q  <= RUN;
              in_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            acc_q <= acc_q + CNT_WIDTH'(1);
            // Leave RUN on the edge that takes the final beat.
            if (acc_q == num_q - CNT_WIDTH'(1)) begin
              state_q  <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (!s1_valid_q) begin
            state_q <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stage 1: capture each accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_inp_q   <= '0;
      s1_out_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_inp_q <= inp;
        s1_out_q <= out;
      end
    end
  end

  // Stage 2: fold the stage-1 beat into the saturating statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt  <= '0;
      err_cnt     <= '0;
      max_abs_err <= '0;
      sum_abs_err <= '0;
      ovf         <= 1'b0;
`ifdef ERR_SQ_EN
      sum_sq_err  <= '0;
`endif
    end else if (start_ok) begin
      sample_cnt  <= '0;
      err_cnt     <= '0;
      max_abs_err <= '0;
      sum_abs_err <= '0;
      ovf         <= 1'b0;
`ifdef ERR_SQ_EN
      sum_sq_err  <= '0;
`endif
    end else if (s1_valid_q) begin
      if (!(&sample_cnt)) sample_cnt <= sample_cnt + CNT_WIDTH'(1);
      if ((|err) && !(&err_cnt)) err_cnt <= err_cnt + CNT_WIDTH'(1);
      if (abs_err > max_abs_err) max_abs_err <= abs_err;
      sum_abs_err <= sum_nxt;
`ifdef ERR_SQ_EN
      sum_sq_err  <= sq_nxt;
      ovf <= ovf | sum_sat | sq_sat | (&sample_cnt) | ((|err) && (&err_cnt));
`else
      ovf <= ovf | sum_sat | (&sample_cnt) | ((|err) && (&err_cnt));
`endif
    end
  end

endmodule

// File: tb/tb_mult_err_monitor.sv
// Self-checking bench for mult_err_monitor: two instances (32-bit and 8-bit
// accumulators) share one stimulus stream; statistics are checked against a
// run-level arithmetic model of the accepted beats.
module tb_mult_err_monitor;

  localparam int BW = 6;
  localparam int OW = 12;
  localparam int CW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_samples;
  logic          in_valid;
  logic [BW-1:0] inp;
  logic [OW-1:0] outv;

  logic          rdy, busy, done, ovf;
  logic [CW-1:0] scnt, ecnt;
  logic [OW:0]   maxe;
  logic [31:0]   sum;
  logic          rdy8, busy8, done8, ovf8;
  logic [CW-1:0] scnt8, ecnt8;
  logic [OW:0]   maxe8;
  logic [7:0]    sum8;
`ifdef ERR_SQ_EN
  logic [63:0]   sq32;
  logic [15:0]   sq8;
`endif

  always #5 clk = ~clk;

  mult_err_monitor #(.BIT_WIDTH(BW), .OUT_WIDTH(OW), .CNT_WIDTH(CW), .ACC_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .in_valid(in_valid),
    .in_ready(rdy), .inp(inp), .out(outv), .busy(busy), .done(done), .sample_cnt(scnt),
    .err_cnt(ecnt), .max_abs_err(maxe), .sum_abs_err(sum), .ovf(ovf)
`ifdef ERR_SQ_EN
    , .sum_sq_err(sq32)
`endif
  );

  mult_err_monitor #(.BIT_WIDTH(BW), .OUT_WIDTH(OW), .CNT_WIDTH(CW), .ACC_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .in_valid(in_valid),
    .in_ready(rdy8), .inp(inp), .out(outv), .busy(busy8), .done(done8), .sample_cnt(scnt8),
    .err_cnt(ecnt8), .max_abs_err(maxe8), .sum_abs_err(sum8), .ovf(ovf8)
`ifdef ERR_SQ_EN
    , .sum_sq_err(sq8)
`endif
  );

  int     n_assert = 0;
  int     n_fail = 0;
  longint m_samples, m_errs, m_max, m_sum, m_sq;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint lim(input int w);
    if (w >= 63) return 64'h7fff_ffff_ffff_ffff;
    return (longint'(1) << w) - 1;
  endfunction

  function automatic longint sat(input longint v, input int w);
    return (v > lim(w)) ? lim(w) : v;
  endfunction

  function automatic logic ovf_exp(input int aw);
    logic o;
    o = (m_samples > lim(CW)) || (m_errs > lim(CW)) || (m_sum > lim(aw));
`ifdef ERR_SQ_EN
    o = o || (m_sq > lim(2 * aw));
`endif
    return o;
  endfunction

  function automatic void model_clear();
    m_samples = 0; m_errs = 0; m_max = 0; m_sum = 0; m_sq = 0;
  endfunction

  // Reference: error is the approximate output minus the true square.
  function automatic void model_accept(input int a, input int o);
    int e;
    int ab;
    e  = o - a * a;
    ab = (e < 0) ? -e : e;
    m_samples++;
    if (e != 0) m_errs++;
    if (ab > m_max) m_max = ab;
    m_sum += ab;
    m_sq  += longint'(e) * longint'(e);
  endfunction

  task automatic check_stats(input string tag);
    check({tag, ".samples"}, 64'(scnt), 64'(sat(m_samples, CW)));
    check({tag, ".errs"}, 64'(ecnt), 64'(sat(m_errs, CW)));
    check({tag, ".max"}, 64'(maxe), 64'(m_max));
    check({tag, ".sum32"}, 64'(sum), 64'(sat(m_sum, 32)));
    check({tag, ".ovf32"}, 64'(ovf), 64'(ovf_exp(32)));
    check({tag, ".samples8"}, 64'(scnt8), 64'(sat(m_samples, CW)));
    check({tag, ".sum8"}, 64'(sum8), 64'(sat(m_sum, 8)));
    check({tag, ".ovf8"}, 64'(ovf8), 64'(ovf_exp(8)));
`ifdef ERR_SQ_EN
    check({tag, ".sq32"}, sq32, 64'(sat(m_sq, 64)));
    check({tag, ".sq8"}, 64'(sq8), 64'(sat(m_sq, 16)));
`endif
  endtask

  task automatic pulse_start(input int n);
    num_samples = CW'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic start_run(input int n);
    pulse_start(n);
    model_clear();
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic feed(input int a, input int o);
    int k;
    inp = a[BW-1:0];
    outv = o[OW-1:0];
    in_valid = 1'b1;
    k = 0;
    while (!rdy && k < 20) begin
      tick();
      k++;
    end
    check("feed_ready", 64'(rdy), 64'(1));
    if (rdy) model_accept(a, o);
    tick();
  endtask

  task automatic wait_done(input string tag);
    int k;
    in_valid = 1'b0;
    k = 0;
    while (!done && k < 50) begin
      tick();
      k++;
    end
    check({tag, ".done"}, 64'(done), 64'(1));
    check({tag, ".done8"}, 64'(done8), 64'(1));
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".ready"}, 64'(rdy), 64'(0));
    check({tag, ".busy"}, 64'(busy), 64'(0));
    check({tag, ".done"}, 64'(done), 64'(0));
    check({tag, ".ovf"}, 64'(ovf), 64'(0));
    check({tag, ".samples"}, 64'(scnt), 64'(0));
    check({tag, ".errs"}, 64'(ecnt), 64'(0));
    check({tag, ".max"}, 64'(maxe), 64'(0));
    check({tag, ".sum"}, 64'(sum), 64'(0));
  endtask

  initial begin
    int cycles;
    int accepted;
    int a;
    int o;

    rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0; inp = '0; outv = '0;
    model_clear();
    repeat (2) tick();
    check_idle_zero("reset");
    rst = 1'b0;
    tick();

    // Directed run with a single off-by-one result.
    start_run(3);
    feed(-32, 1024);
    feed(5, 24);
    feed(3, 9);
    wait_done("s1");
    check_stats("s1");
    check("s1.ready_done", 64'(rdy), 64'(0));
    repeat (3) tick();
    check("s1.done_held", 64'(done), 64'(1));
    check_stats("s1_held");

    // Empty run goes straight through DRAIN.
    start_run(0);
    check("s2.busy", 64'(busy), 64'(1));
    check("s2.ready0", 64'(rdy), 64'(0));
    check("s2.not_done", 64'(done), 64'(0));
    tick();
    check("s2.done", 64'(done), 64'(1));
    check("s2.ready1", 64'(rdy), 64'(0));
    check_stats("s2");

    // Long exact stream held valid every cycle: no stalls allowed.
    start_run(100000);
    cycles = 0;
    accepted = 0;
    while (accepted < 100000 && cycles < 110000) begin
      a = int'($urandom_range(0, 63)) - 32;
      inp = a[BW-1:0];
      outv = OW'(a * a);
      in_valid = 1'b1;
      if (rdy) begin
        model_accept(a, a * a);
        accepted++;
      end
      cycles++;
      tick();
    end
    in_valid = 1'b0;
    check("s3.cycles", 64'(cycles), 64'(100000));
    wait_done("s3");
    check_stats("s3");

    // Large errors saturate the 8-bit accumulator.
    start_run(4);
    repeat (4) feed(0, -100);
    wait_done("s4");
    check_stats("s4");
    check("s4.sum8_sat", 64'(sum8), 64'(255));
    check("s4.ovf8", 64'(ovf8), 64'(1));

    // Reset mid-run discards everything.
    start_run(5);
    feed(1, 1);
    feed(2, 4);
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    check_idle_zero("s5_rst");
    rst = 1'b0;
    tick();
    tick();
    check_idle_zero("s5_post");
    start_run(1);
    feed(-1, 2);
    in_valid = 1'b0;
    check("s5.lat0", 64'(scnt), 64'(0));
    tick();
    check("s5.lat1", 64'(scnt), 64'(1));
    wait_done("s5");
    check_stats("s5");
    check("s5.errs1", 64'(ecnt), 64'(1));
    check("s5.max1", 64'(maxe), 64'(1));

    // Sparse valid with an ignored start pulse in the middle of the run.
    start_run(6);
    for (int c = 0; c < 60 && !done; c++) begin
      a = int'($urandom_range(0, 63)) - 32;
      o = int'($urandom_range(0, 4095)) - 2048;
      inp = a[BW-1:0];
      outv = o[OW-1:0];
      in_valid = c[0];
      start = (c == 5);
      num_samples = CW'(2);
      if (in_valid && rdy) model_accept(a, o);
      tick();
    end
    start = 1'b0;
    in_valid = 1'b0;
    wait_done("s6");
    check_stats("s6");
    check("s6.samples6", 64'(scnt), 64'(6));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
